// File: rtl/ysyx_25020042_pkg.sv
// Shared types and constants for the ysyx_25020042 memory responder slice.
package ysyx_25020042_pkg;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Word-granular window test; the 31-bit depth allows a window of 2^30 words.
  function automatic logic word_out_of_range(input logic [29:0] word,
                                             input logic [29:0] base_word,
                                             input logic [30:0] depth_words);
    return (word < base_word) || ({1'b0, word - base_word} >= depth_words);
  endfunction

endpackage

// File: rtl/ysyx_25020042_sram_array.sv
// Word storage split into byte lanes: one synchronous masked write port and
// one registered read port whose output register can be cleared.
module ysyx_25020042_sram_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    wmask,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic          rd_en,
  input  logic          rd_clr,
  output logic [31:0]   rd_data
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] rd_reg;

    always_ff @(posedge clk) begin
      if (we && wmask[gi]) begin
        mem[addr] <= wdata[8*gi +: 8];
      end
    end

    // Read-before-write on a shared address; the clear only touches the output register.
    always_ff @(posedge clk) begin
      if (rd_clr) begin
        rd_reg <= 8'h00;
      end else if (rd_en) begin
        rd_reg <= mem[addr];
      end
    end

    assign rd_data[8*gi +: 8] = rd_reg;
  end

endmodule

// File: rtl/ysyx_25020042_mem_resp.sv
// Single-outstanding memory responder with fixed request-to-response latency,
// byte-masked stores and an address window check.
module ysyx_25020042_mem_resp
  import ysyx_25020042_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
  localparam logic [LAT_W-1:0] WAIT_INIT = LAT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);

  state_e           state_reg;
  logic [LAT_W-1:0] cnt_reg;
  logic [AW-1:0]    idx_reg;
  logic             wen_reg;
  logic             err_reg;
  logic [31:0]      wdata_reg;
  logic [3:0]       wmask_reg;
  logic             req_ready_reg;
  logic             rsp_valid_reg;
  logic             rsp_err_reg;

  logic             req_err;
  logic [AW-1:0]    cur_idx;
  logic             cur_wen;
  logic             cur_err;
  logic [31:0]      cur_wdata;
  logic [3:0]       cur_wmask;
  logic             enter_resp;
  logic             mem_we;
  logic             mem_rd_en;
  logic             mem_rd_clr;
  logic             addr_lsb_unused;

  assign addr_lsb_unused = ^req_addr[1:0];
  assign req_err = word_out_of_range(req_addr[31:2], BASE_WORD, 31'(DEPTH_WORDS));

  // With LATENCY=1 the memory is accessed on the accepting edge, so it sees the live request.
  always_comb begin
    cur_idx    = idx_reg;
    cur_wen    = wen_reg;
    cur_err    = err_reg;
    cur_wdata  = wdata_reg;
    cur_wmask  = wmask_reg;
    enter_resp = 1'b0;
    if (state_reg == ST_IDLE) begin
      cur_idx    = AW'(req_addr[31:2] - BASE_WORD);
      cur_wen    = req_wen;
      cur_err    = req_err;
      cur_wdata  = req_wdata;
      cur_wmask  = req_wmask;
      enter_resp = !rst && req_valid && (LATENCY == 1);
    end else if (state_reg == ST_WAIT) begin
      enter_resp = !rst && (cnt_reg == '0);
    end
    mem_we     = enter_resp && cur_wen && !cur_err;
    mem_rd_en  = enter_resp && !cur_wen && !cur_err;
    mem_rd_clr = rst || (enter_resp && (cur_wen || cur_err));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            idx_reg       <= cur_idx;
            wen_reg       <= req_wen;
            err_reg       <= req_err;
            wdata_reg     <= req_wdata;
            wmask_reg     <= req_wmask;
            req_ready_reg <= 1'b0;
            if (LATENCY == 1) begin
              state_reg     <= ST_RESP;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= req_err;
            end else begin
              state_reg <= ST_WAIT;
              cnt_reg   <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_reg == '0) begin
            state_reg     <= ST_RESP;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= err_reg;
          end else begin
            cnt_reg <= cnt_reg - LAT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_reg     <= ST_IDLE;
            rsp_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  ysyx_25020042_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_sram (
    .clk    (clk),
    .we     (mem_we),
    .wmask  (cur_wmask),
    .addr   (cur_idx),
    .wdata  (cur_wdata),
    .rd_en  (mem_rd_en),
    .rd_clr (mem_rd_clr),
    .rd_data(rsp_rdata)
  );

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_ysyx_25020042_mem_resp.sv
// Scoreboard bench: instance 0 uses LATENCY=2, instance 1 uses LATENCY=1.
module tb_ysyx_25020042_mem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic        req_wen   [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wmask [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  ysyx_25020042_mem_resp #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(2)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_wen(req_wen[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  ysyx_25020042_mem_resp #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_wen(req_wen[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int          acc;
    string       name;
  } exp_t;

  exp_t q[$];

  int          stall_cfg = 0;
  logic        busy       [2] = '{1'b0, 1'b0};
  int          stall_left [2] = '{0, 0};
  logic        hs_pending [2] = '{1'b0, 1'b0};
  logic [31:0] first_rdata[2];
  logic        first_err  [2];

  // Monitor: owns rsp_ready, pops the scoreboard on the first cycle of each response.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (rsp_valid[k] === 1'b1) begin
        if (!busy[k]) begin
          busy[k]        = 1'b1;
          first_rdata[k] = rsp_rdata[k];
          first_err[k]   = rsp_err[k];
          stall_left[k]  = stall_cfg;
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp inst=%0d actual=rsp_valid required=no_response", k);
          end else begin
            e = q.pop_front();
            chk({e.name, "_inst"}, k, e.inst);
            chk({e.name, "_rdata"}, rsp_rdata[k], e.rdata);
            chk({e.name, "_err"}, {31'd0, rsp_err[k]}, {31'd0, e.err});
            chk({e.name, "_latency"}, cyc + 1 - e.acc, lat(k));
            $display("txn %s inst=%0d rdata=0x%08h err=%0b cycles=%0d", e.name, k,
                     rsp_rdata[k], rsp_err[k], cyc + 1 - e.acc);
          end
        end else begin
          chk("hold_rdata", rsp_rdata[k], first_rdata[k]);
          chk("hold_err", {31'd0, rsp_err[k]}, {31'd0, first_err[k]});
        end
        chk("req_ready_during_rsp", {31'd0, req_ready[k]}, 32'd0);
        rsp_ready[k] = (stall_left[k] == 0);
        if (stall_left[k] > 0) stall_left[k]--;
        hs_pending[k] = rsp_ready[k];
      end else begin
        if (hs_pending[k]) begin
          chk("req_ready_after_hs", {31'd0, req_ready[k]}, 32'd1);
          hs_pending[k] = 1'b0;
          busy[k]       = 1'b0;
        end
        rsp_ready[k] = 1'b0;
      end
    end
  end

  task automatic issue(input int k, input logic [31:0] addr, input logic wen,
                       input logic [31:0] wdata, input logic [3:0] wmask,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input string name, input bit push, output int acc);
    int t = 0;
    acc = -1;
    @(negedge clk);
    while (req_ready[k] !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (req_ready[k] !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s_accept_timeout actual=req_ready_low required=req_ready_high", name);
      return;
    end
    req_valid[k] = 1'b1;
    req_addr[k]  = addr;
    req_wen[k]   = wen;
    req_wdata[k] = wdata;
    req_wmask[k] = wmask;
    acc = cyc + 1;
    if (push) q.push_back('{k, exp_rdata, exp_err, acc, name});
    @(posedge clk);
    #1;
    // Scramble the request bus so a design that fails to capture it shows up later.
    req_valid[k] = 1'b0;
    req_addr[k]  = 32'h8000_0040;
    req_wen[k]   = ~wen;
    req_wdata[k] = $urandom;
    req_wmask[k] = 4'hF;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((q.size() != 0 || busy[0] || busy[1]) && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    checks++;
    if (q.size() != 0 || busy[0] || busy[1]) begin
      failures++;
      $display("FAIL %s_drain actual=pending=%0d required=pending=0", name, q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, a1, a2;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      req_addr[k]  = 32'h0;
      req_wen[k]   = 1'b0;
      req_wdata[k] = 32'h0;
      req_wmask[k] = 4'h0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata[0], 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err[0]}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready[0]}, 32'd1);
    chk("rst_req_ready_l1", {31'd0, req_ready[1]}, 32'd1);

    issue(0, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, "st_deadbeef", 1, a0);
    issue(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, "ld_deadbeef", 1, a0);
    issue(0, 32'h8000_0020, 1'b1, 32'h1122_3344, 4'hF, 32'h0, 1'b0, "st_base_word", 1, a0);
    issue(0, 32'h8000_0020, 1'b1, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, "st_mask0101", 1, a0);
    issue(0, 32'h8000_0020, 0, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0, "ld_masked", 1, a0);
    issue(0, 32'h8000_0000, 1'b1, 32'h5566_7788, 4'hF, 32'h0, 1'b0, "st_word0", 1, a0);
    issue(0, 32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, "ld_below", 1, a0);
    issue(0, 32'h8000_1000, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "st_above", 1, a0);
    issue(0, 32'h8000_0FFC, 1'b1, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0, "st_last", 1, a0);
    issue(0, 32'h8000_0FFC, 1'b0, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, "ld_last", 1, a0);
    issue(0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h5566_7788, 1'b0, "ld_word0", 1, a0);
    issue(0, 32'h8000_0010, 1'b1, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, "st_mask0", 1, a0);
    issue(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, "ld_after_mask0", 1, a0);
    drain("main");

    stall_cfg = 5;
    issue(0, 32'h8000_0020, 1'b0, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0, "ld_stalled", 1, a0);
    drain("stall");
    stall_cfg = 0;

    issue(0, 32'h8000_0010, 1'b1, 32'h1234_5678, 4'hF, 32'h0, 1'b0, "st_aborted", 0, a0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("wait_rst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    @(negedge clk);
    chk("wait_rst_rsp_valid_later", {31'd0, rsp_valid[0]}, 32'd0);
    issue(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, "ld_after_rst", 1, a0);
    drain("reset");

    issue(1, 32'h8000_0000, 1'b1, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, "l1_st", 1, a0);
    issue(1, 32'h8000_0002, 1'b0, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, "l1_ld_mis", 1, a1);
    issue(1, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, "l1_ld", 1, a2);
    chk("l1_spacing_a", a1 - a0, 32'd2);
    chk("l1_spacing_b", a2 - a1, 32'd2);
    drain("l1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
